nes_gamepad_reader: RTL and testbench

Serial NES-style gamepad reader that drives the pad's latch/clock lines, shifts in the eight button bits and presents them as a parallel active-high byte plus a one-cycle update strobe. It sits beside the game core in the board top level and feeds the `I_SW` switch vector in place of the USB gamepad path. Its output byte layout and strobe match `usb_gamepad_data` / `usb_gamepad_ena`.

---
 rtl/nes_gamepad_reader_pkg.sv | 23 ++
 rtl/nes_gamepad_reader_sync2.sv | 22 ++
 rtl/nes_gamepad_reader.sv | 142 ++++++++++++++
 tb/tb_nes_gamepad_reader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_gamepad_reader_pkg.sv
// Shared types for the NES gamepad reader: FSM states
// and button bit positions used for the switch mapping.
package nes_gamepad_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    GAP,
    CLK_LO,
    CLK_HI,
    DONE
  } state_t;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_gamepad_reader_sync2.sv
// Two-flop synchronizer for the pad data line; resets high.
// Ports: clk, rst (sync, active-high), d (async in), q (synced out).
module nes_gamepad_reader_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_gamepad_reader.sv
// NES pad reader: drives latch/clock, shifts in 8 buttons LSB-first,
// publishes an active-high byte with a one-cycle strobe.
// Ports: clk24, rst (sync, active-high), pad_latch, pad_clk,
//   pad_data (async, active-low), gamepad_data[7:0], gamepad_ena.
// Option: PAD_FILTER_EN -- update only when two polls agree.
module nes_gamepad_reader
  import nes_gamepad_reader_pkg::*;
#(
  parameter int HALF_CYCLES = 144,
  parameter int POLL_CYCLES = 400000
) (
  input  logic       clk24,
  input  logic       rst,
  output logic       pad_latch,
  output logic       pad_clk,
  input  logic       pad_data,
  output logic [7:0] gamepad_data,
  output logic       gamepad_ena
);

  localparam int PHW = $clog2(2 * HALF_CYCLES);
  localparam int PLW = $clog2(POLL_CYCLES);

  localparam logic [PHW-1:0] LATCH_END =
    PHW'(2 * HALF_CYCLES - 1);
  localparam logic [PHW-1:0] HALF_END =
    PHW'(HALF_CYCLES - 1);
  localparam logic [PLW-1:0] POLL_MAX =
    PLW'(POLL_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [PHW-1:0]   phase;
  logic [2:0]       bit_cnt;
  logic [PLW-1:0]   poll_cnt;
  logic [7:0]       shreg;
  logic [7:0]       poll_word;
  logic             take;
  logic             publish;
  logic             pad_sync;
  logic             sample;
`ifdef PAD_FILTER_EN
  logic [7:0]       prev_word;
`endif

  nes_gamepad_reader_sync2 u_sync2 (
    .clk (clk24),
    .rst (rst),
    .d   (pad_data),
    .q   (pad_sync)
  );

  assign sample = ~pad_sync;

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    unique case (state)
      IDLE: begin
        if (poll_cnt == '0) state_nxt = LATCH;
      end
      LATCH: begin
        if (phase == LATCH_END) state_nxt = GAP;
      end
      GAP: begin
        if (phase == HALF_END) begin
          take      = 1'b1;
          state_nxt = CLK_LO;
        end
      end
      CLK_LO: begin
        if (phase == HALF_END) state_nxt = CLK_HI;
      end
      CLK_HI: begin
        if (phase == HALF_END) begin
          take      = 1'b1;
          state_nxt = (bit_cnt == 3'd7) ? DONE : CLK_LO;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The last bit lands in the same edge that enters DONE, so the
  // published word merges the live sample with the shift register.
  always_comb begin
    poll_word          = shreg;
    poll_word[bit_cnt] = sample;
  end

  assign publish = take && (state == CLK_HI) &&
                   (bit_cnt == 3'd7);

  assign pad_latch = (state == LATCH);
  assign pad_clk   = (state != CLK_LO);

  always_ff @(posedge clk24) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= '0;
      bit_cnt      <= 3'd0;
      poll_cnt     <= '0;
      shreg        <= 8'h00;
      gamepad_data <= 8'h00;
      gamepad_ena  <= 1'b0;
`ifdef PAD_FILTER_EN
      prev_word    <= 8'h00;
`endif
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == IDLE)
        phase <= '0;
      else
        phase <= phase + 1'b1;
      if (poll_cnt == POLL_MAX)
        poll_cnt <= '0;
      else
        poll_cnt <= poll_cnt + 1'b1;
      gamepad_ena <= publish;
      if (take) begin
        shreg   <= poll_word;
        bit_cnt <= bit_cnt + 3'd1;
      end
`ifdef PAD_FILTER_EN
      if (publish) begin
        prev_word <= poll_word;
        if (poll_word == prev_word)
          gamepad_data <= poll_word;
      end
`else
      if (publish)
        gamepad_data <= poll_word;
`endif
    end
  end

endmodule

// File: tb/tb_nes_gamepad_reader.sv
// Bench for nes_gamepad_reader: pad model, scoreboard queue,
// vector table and hand-written timing sequences.
module tb_nes_gamepad_reader;
  import nes_gamepad_reader_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_def = 1'b1;
  logic       pad_latch, pad_clk, pad_data;
  logic [7:0] gamepad_data;
  logic       gamepad_ena;
  logic       lat_d, clk_d, ena_d;
  logic [7:0] data_d;

  always #5 clk = ~clk;

  nes_gamepad_reader #(
    .HALF_CYCLES (4),
    .POLL_CYCLES (100)
  ) u_dut (
    .clk24        (clk),
    .rst          (rst),
    .pad_latch    (pad_latch),
    .pad_clk      (pad_clk),
    .pad_data     (pad_data),
    .gamepad_data (gamepad_data),
    .gamepad_ena  (gamepad_ena)
  );

  nes_gamepad_reader u_def (
    .clk24        (clk),
    .rst          (rst_def),
    .pad_latch    (lat_d),
    .pad_clk      (clk_d),
    .pad_data     (1'b1),
    .gamepad_data (data_d),
    .gamepad_ena  (ena_d)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h want %0h", nm, act, req);
  endtask

  // Pad model: parallel load while latched, shift on clk rise.
  logic [7:0] pad_word = 8'h00;
  logic [7:0] sb_word  = 8'h00;
  logic [7:0] sh       = 8'hFF;
  logic       ovr_en   = 1'b0;
  logic       ovr_val  = 1'b1;

  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) sh = ~pad_word;
    else sh = {1'b1, sh[7:1]};
  end

  assign pad_data = ovr_en ? ovr_val : sh[0];

  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Scoreboard: push expectation at latch rise, pop on strobe.
  logic [7:0] exp_q[$];
  logic [7:0] m_prev = 8'h00;
  logic [7:0] m_out  = 8'h00;
  logic       lat_q  = 1'b0;
  int         last_ena = 0;
  int         prev_ena = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_prev = 8'h00;
      m_out  = 8'h00;
    end else begin
      if (pad_latch && !lat_q) begin
`ifdef PAD_FILTER_EN
        if (sb_word == m_prev) m_out = sb_word;
        m_prev = sb_word;
        exp_q.push_back(m_out);
`else
        exp_q.push_back(sb_word);
`endif
      end
      if (gamepad_ena) begin
        prev_ena = last_ena;
        last_ena = cyc;
        chk("sb_pending", exp_q.size(), 1);
        if (exp_q.size() > 0)
          chk("sb_data", gamepad_data, exp_q.pop_front());
      end
    end
    lat_q = pad_latch;
  end

  task automatic wait_ena();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gamepad_ena && n < 400);
    chk("ena_seen", gamepad_ena, 1);
  endtask

  task automatic wait_latch(input logic lvl);
    int n = 0;
    while (pad_latch !== lvl && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("latch_wait", pad_latch, lvl);
  endtask

  // Default-parameter instance: long latch and poll timing.
  logic def_done = 1'b0;
  initial begin
    int first_lat = -1;
    int lat_len = 0;
    int ena_at = -1;
    wait (rst_def == 1'b0);
    for (int c = 1; c <= 3000 && ena_at < 0; c++) begin
      @(negedge clk);
      if (lat_d) begin
        if (first_lat < 0) first_lat = c;
        lat_len++;
      end
      if (ena_d) ena_at = c;
    end
    chk("def_latch_start", first_lat, 1);
    chk("def_latch_width", lat_len, 288);
    chk("def_ena_cycle", ena_at, 2449);
    chk("def_data", data_d, 8'h00);
    def_done = 1'b1;
  end

  typedef struct {
    logic [7:0] buttons;
    logic [7:0] want;
  } vec_t;

  vec_t vecs[4];

  logic lat_r[0:74];
  logic pclk_r[0:74];
  logic ena_r[0:74];

  initial begin
    int first_lat, lat_len, pulses, low_len;
    int ena_at, ena_n, n;
    logic pc_prev;

    vecs[0].buttons = (8'd1 << BTN_A) | (8'd1 << BTN_START) |
                      (8'd1 << BTN_RIGHT);
    vecs[0].want    = 8'h89;
    vecs[1].buttons = 8'hFF;
    vecs[1].want    = 8'hFF;
    vecs[2].buttons = 8'h00;
    vecs[2].want    = 8'h00;
    vecs[3].buttons = (8'd1 << BTN_B) | (8'd1 << BTN_UP) |
                      (8'd1 << BTN_LEFT) | (8'd1 << BTN_SELECT);
    vecs[3].want    = 8'h56;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_latch", pad_latch, 0);
    chk("rst_clk", pad_clk, 1);
    chk("rst_data", gamepad_data, 8'h00);
    chk("rst_ena", gamepad_ena, 0);

    // First poll, unplugged pad
    rst = 1'b0;
    rst_def = 1'b0;
    lat_r[0] = pad_latch;
    pclk_r[0] = pad_clk;
    ena_r[0] = gamepad_ena;
    for (int c = 1; c < 75; c++) begin
      @(negedge clk);
      lat_r[c] = pad_latch;
      pclk_r[c] = pad_clk;
      ena_r[c] = gamepad_ena;
    end
    first_lat = -1; lat_len = 0; pulses = 0;
    low_len = 0; ena_at = -1; ena_n = 0;
    for (int c = 1; c < 75; c++) begin
      if (lat_r[c]) begin
        if (first_lat < 0) first_lat = c;
        lat_len++;
      end
      if (!pclk_r[c]) begin
        low_len++;
        if (pclk_r[c-1]) pulses++;
      end
      if (ena_r[c]) begin
        ena_n++;
        if (ena_at < 0) ena_at = c;
      end
    end
    chk("latch_start", first_lat, 1);
    chk("latch_width", lat_len, 8);
    chk("clk_pulses", pulses, 7);
    chk("clk_low_total", low_len, 28);
    chk("ena_cycle", ena_at, 69);
    chk("ena_count", ena_n, 1);

    // Vector table: each word held for two polls
    for (int i = 0; i < 4; i++) begin
      pad_word = vecs[i].buttons;
      sb_word  = vecs[i].buttons;
      wait_ena();
      wait_ena();
      chk("vec_data", gamepad_data, vecs[i].want);
      chk("poll_period", last_ena - prev_ena, 100);
    end

    // Alternating patterns, then a repeated one
    for (int i = 0; i < 6; i++) begin
      pad_word = (i < 4 && i[0]) ? 8'hAA : 8'h55;
      sb_word  = pad_word;
      wait_ena();
    end
    chk("alt_final", gamepad_data, 8'h55);

    // Reset during the low phase of bit 3
    pad_word = 8'h00;
    sb_word  = 8'h00;
    wait_latch(1'b1);
    pulses = 0;
    pc_prev = 1'b1;
    n = 0;
    while (pulses < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (!pad_clk && pc_prev) pulses++;
      pc_prev = pad_clk;
    end
    chk("bit3_pulse_found", pulses, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_clk", pad_clk, 1);
    chk("abort_latch", pad_latch, 0);
    chk("abort_data", gamepad_data, 8'h00);
    chk("abort_ena", gamepad_ena, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_latch", pad_latch, 1);
    wait_ena();

    // Sync latency: level held to the 2-cycles-early edge counts
    pad_word = 8'h00;
    sb_word  = 8'h01;
    wait_latch(1'b1);
    wait_latch(1'b0);
    ovr_val = 1'b0;
    ovr_en  = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    ovr_en = 1'b0;
    wait_ena();

    // One cycle too late: sampling edge must not see it
    sb_word = 8'h00;
    wait_latch(1'b1);
    wait_latch(1'b0);
    repeat (2) @(negedge clk);
    ovr_val = 1'b0;
    ovr_en  = 1'b1;
    @(negedge clk);
    @(posedge clk);
    ovr_en = 1'b0;
    wait_ena();

    n = 0;
    while (!def_done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("def_monitor_done", def_done, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
